// File: rtl/pio_pkg.sv
// Shared definitions for the PIO host front end: action codes, register map
// and controller state encoding.
package pio_pkg;

   localparam logic [3:0] ACT_NONE  = 4'd0;
   localparam logic [3:0] ACT_INSTR = 4'd1;
   localparam logic [3:0] ACT_PEND  = 4'd2;
   localparam logic [3:0] ACT_PULL  = 4'd3;
   localparam logic [3:0] ACT_PUSH  = 4'd4;
   localparam logic [3:0] ACT_GRPS  = 4'd5;
   localparam logic [3:0] ACT_EN    = 4'd6;
   localparam logic [3:0] ACT_DIV   = 4'd7;
   localparam logic [3:0] ACT_IMM   = 4'd9;
   localparam logic [3:0] ACT_SHIFT = 4'd10;
   localparam logic [3:0] ACT_INTR  = 4'd11;

   localparam logic [7:0] INSTR_BASE = 8'h00;
   localparam logic [7:0] MREG_BASE  = 8'h20;
   localparam logic [7:0] TXF_BASE   = 8'h30;
   localparam logic [7:0] RXF_BASE   = 8'h34;
   localparam logic [7:0] IMM_BASE   = 8'h38;
   localparam logic [7:0] CTRL       = 8'h3C;
   localparam logic [7:0] INTR       = 8'h3D;
   localparam logic [7:0] VERSION    = 8'h3E;
   localparam logic [7:0] FSTAT      = 8'h3F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_WAIT,
      S_RESP,
      S_HOLD
   } state_t;

   // A FIFO op is blocked while its target machine's FIFO cannot take it.
   function automatic logic fifo_blocked(input logic [3:0] act,
                                         input logic [1:0] m,
                                         input logic [3:0] tx_full,
                                         input logic [3:0] rx_empty);
      return ((act == ACT_PUSH) && tx_full[m]) || ((act == ACT_PULL) && rx_empty[m]);
   endfunction

endpackage

// File: rtl/pio_bus_ctrl_if.sv
// Host request/response bus of the PIO front end; the host is the master.
interface pio_bus_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/pio_addr_decode.sv
// Combinational register-map decode: maps a host address and direction onto
// at most one PIO action, or flags the access as local or erroneous.
module pio_addr_decode
   import pio_pkg::*;
(
   input  logic [7:0] addr_i,
   input  logic       write_i,
   output logic [3:0] action_o,
   output logic [1:0] mindex_o,
   output logic [4:0] index_o,
   output logic       is_fifo_o,
   output logic       is_local_o,
   output logic       is_read_o,
   output logic       err_o
);

   always_comb begin
      action_o   = ACT_NONE;
      mindex_o   = 2'd0;
      index_o    = 5'd0;
      is_fifo_o  = 1'b0;
      is_local_o = 1'b0;
      is_read_o  = ~write_i;
      err_o      = 1'b0;

      if (addr_i[7:5] == INSTR_BASE[7:5]) begin
         if (write_i) begin
            action_o = ACT_INSTR;
            index_o  = addr_i[4:0];
         end else begin
            err_o = 1'b1;
         end
      end else if (addr_i[7:4] == MREG_BASE[7:4]) begin
         if (write_i) begin
            mindex_o = addr_i[3:2];
            case (addr_i[1:0])
               2'd0:    action_o = ACT_PEND;
               2'd1:    action_o = ACT_GRPS;
               2'd2:    action_o = ACT_DIV;
               default: action_o = ACT_SHIFT;
            endcase
         end else begin
            err_o = 1'b1;
         end
      end else if (addr_i[7:2] == TXF_BASE[7:2]) begin
         if (write_i) begin
            action_o  = ACT_PUSH;
            mindex_o  = addr_i[1:0];
            is_fifo_o = 1'b1;
         end else begin
            err_o = 1'b1;
         end
      end else if (addr_i[7:2] == RXF_BASE[7:2]) begin
         if (!write_i) begin
            action_o  = ACT_PULL;
            mindex_o  = addr_i[1:0];
            is_fifo_o = 1'b1;
         end else begin
            err_o = 1'b1;
         end
      end else if (addr_i[7:2] == IMM_BASE[7:2]) begin
         if (write_i) begin
            action_o = ACT_IMM;
            mindex_o = addr_i[1:0];
         end else begin
            err_o = 1'b1;
         end
      end else if (addr_i == CTRL) begin
         if (write_i) action_o = ACT_EN;
         else         err_o    = 1'b1;
      end else if (addr_i == INTR) begin
         if (!write_i) action_o = ACT_INTR;
         else          err_o    = 1'b1;
      end else if (addr_i == VERSION) begin
         // Version read still walks the PIO read path with a NONE action.
         if (write_i) err_o = 1'b1;
      end else if (addr_i == FSTAT) begin
         if (!write_i) is_local_o = 1'b1;
         else          err_o      = 1'b1;
      end else begin
         err_o = 1'b1;
      end
   end

endmodule

// File: rtl/pio_bus_ctrl.sv
// Host-facing front end that turns one bus request into at most one
// single-cycle PIO command, stalling FIFO ops until the FIFO can take them.
module pio_bus_ctrl
   import pio_pkg::*;
#(
   parameter int STALL_TIMEOUT = 255,
   parameter int HOLDOFF       = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   pio_bus_ctrl_if.slave bus,
   output logic [3:0]   action,
   output logic [1:0]   mindex,
   output logic [4:0]   index,
   output logic [31:0]  din,
   input  logic [31:0]  dout,
   input  logic [3:0]   tx_full,
   input  logic [3:0]   rx_empty
);

   localparam int WAIT_W = $clog2(STALL_TIMEOUT + 1);
   localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STALL_TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   logic [3:0]  lat_action_q, lat_action_d;
   logic [1:0]  lat_mindex_q, lat_mindex_d;
   logic [4:0]  lat_index_q, lat_index_d;
   logic [31:0] lat_wdata_q, lat_wdata_d;
   logic        lat_write_q, lat_write_d;
   logic        lat_read_q, lat_read_d;
   logic        lat_fifo_q, lat_fifo_d;

   logic [3:0]  action_q, action_d;
   logic [1:0]  mindex_q, mindex_d;
   logic [4:0]  index_q, index_d;
   logic [31:0] din_q, din_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [3:0]  dec_action;
   logic [1:0]  dec_mindex;
   logic [4:0]  dec_index;
   logic        dec_fifo, dec_local, dec_read, dec_err;

   pio_addr_decode u_decode (
      .addr_i     (bus.req_addr),
      .write_i    (bus.req_write),
      .action_o   (dec_action),
      .mindex_o   (dec_mindex),
      .index_o    (dec_index),
      .is_fifo_o  (dec_fifo),
      .is_local_o (dec_local),
      .is_read_o  (dec_read),
      .err_o      (dec_err)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         wait_cnt_q   <= '0;
         hold_cnt_q   <= '0;
         lat_action_q <= ACT_NONE;
         lat_mindex_q <= '0;
         lat_index_q  <= '0;
         lat_wdata_q  <= '0;
         lat_write_q  <= 1'b0;
         lat_read_q   <= 1'b0;
         lat_fifo_q   <= 1'b0;
         action_q     <= ACT_NONE;
         mindex_q     <= '0;
         index_q      <= '0;
         din_q        <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         lat_action_q <= lat_action_d;
         lat_mindex_q <= lat_mindex_d;
         lat_index_q  <= lat_index_d;
         lat_wdata_q  <= lat_wdata_d;
         lat_write_q  <= lat_write_d;
         lat_read_q   <= lat_read_d;
         lat_fifo_q   <= lat_fifo_d;
         action_q     <= action_d;
         mindex_q     <= mindex_d;
         index_q      <= index_d;
         din_q        <= din_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   // Command outputs are registered: loading them on the transition into
   // ISSUE makes them visible for exactly the ISSUE cycle.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      lat_action_d = lat_action_q;
      lat_mindex_d = lat_mindex_q;
      lat_index_d  = lat_index_q;
      lat_wdata_d  = lat_wdata_q;
      lat_write_d  = lat_write_q;
      lat_read_d   = lat_read_q;
      lat_fifo_d   = lat_fifo_q;
      action_d     = ACT_NONE;
      mindex_d     = mindex_q;
      index_d      = index_q;
      din_d        = din_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               lat_action_d = dec_action;
               lat_mindex_d = dec_mindex;
               lat_index_d  = dec_index;
               lat_wdata_d  = bus.req_wdata;
               lat_write_d  = bus.req_write;
               lat_read_d   = dec_read;
               lat_fifo_d   = dec_fifo;
               rsp_rdata_d  = '0;
               rsp_err_d    = 1'b0;
               if (dec_err) begin
                  rsp_err_d = 1'b1;
                  state_d   = S_RESP;
               end else if (dec_local) begin
                  rsp_rdata_d = {24'd0, rx_empty, tx_full};
                  state_d     = S_RESP;
               end else if (dec_fifo && fifo_blocked(dec_action, dec_mindex, tx_full, rx_empty)) begin
                  wait_cnt_d = '0;
                  state_d    = S_WAIT;
               end else begin
                  action_d = dec_action;
                  mindex_d = dec_mindex;
                  index_d  = dec_index;
                  if (bus.req_write) din_d = bus.req_wdata;
                  state_d  = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            state_d = lat_read_q ? S_CAPTURE : S_RESP;
         end
         S_CAPTURE: begin
            rsp_rdata_d = dout;
            state_d     = S_RESP;
         end
         S_WAIT: begin
            if (!fifo_blocked(lat_action_q, lat_mindex_q, tx_full, rx_empty)) begin
               action_d = lat_action_q;
               mindex_d = lat_mindex_q;
               index_d  = lat_index_q;
               if (lat_write_q) din_d = lat_wdata_q;
               state_d  = S_ISSUE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               rsp_err_d = 1'b1;
               state_d   = S_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         S_RESP: begin
            hold_cnt_d = '0;
            state_d    = (lat_fifo_q && (HOLDOFF > 0)) ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) state_d = S_IDLE;
            else                         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.req_ready = (state_q == S_IDLE) && reset_n;
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   assign action = action_q;
   assign mindex = mindex_q;
   assign index  = index_q;
   assign din    = din_q;

endmodule

// File: tb/tb_pio_bus_ctrl.sv
// Directed bench for pio_bus_ctrl: a small registered PIO model answers reads
// and a response scoreboard checks data, error flag and response cycle.
module tb_pio_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  action;
   logic [1:0]  mindex;
   logic [4:0]  index;
   logic [31:0] din;
   logic [31:0] dout;
   logic [3:0]  tx_full;
   logic [3:0]  rx_empty;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          at;
      logic [31:0] rd;
      logic        er;
   } exp_t;
   exp_t sb[$];

   pio_bus_ctrl_if bus();

   pio_bus_ctrl #(.STALL_TIMEOUT(255), .HOLDOFF(2)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .action   (action),
      .mindex   (mindex),
      .index    (index),
      .din      (din),
      .dout     (dout),
      .tx_full  (tx_full),
      .rx_empty (rx_empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // PIO read port model: dout answers the action of the previous cycle.
   always @(posedge clk) begin
      case (action)
         4'd0:    dout <= 32'h0100_0000;
         4'd11:   dout <= 32'h0000_0ABC;
         4'd3:    dout <= 32'hD000_0000 | {30'd0, mindex};
         default: dout <= 32'hDEAD_BEEF;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_cycle", 32'(cyc), 32'(e.at));
            check("rsp_rdata", bus.rsp_rdata, e.rd);
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.er});
            $display("rsp cyc=%0d rdata=%h err=%0d", cyc, bus.rsp_rdata, bus.rsp_err);
         end
      end
   end

   // Present one request at a negedge; returns at the negedge of cycle A+1.
   task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input bit exp_rsp, input logic [31:0] exp_rd, input logic exp_er,
                       input int lat);
      int n;
      exp_t e;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      if (exp_rsp) begin
         e.at = cyc + lat;
         e.rd = exp_rd;
         e.er = exp_er;
         sb.push_back(e);
      end
      $display("req cyc=%0d write=%0d addr=%h wdata=%h", cyc, w, a, d);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   logic [7:0] waddr [7] = '{8'h20, 8'h25, 8'h2A, 8'h2F, 8'h3A, 8'h3C, 8'h1F};
   logic [3:0] wact  [7] = '{4'd2, 4'd5, 4'd7, 4'd10, 4'd9, 4'd6, 4'd1};
   logic [1:0] wm    [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
   logic [4:0] widx  [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31};
   logic       ew    [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [7:0] ea    [6] = '{8'h34, 8'h05, 8'h40, 8'h3F, 8'h30, 8'h2C};

   initial begin
      int bad;
      reset_n       = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = 8'h00;
      bus.req_wdata = 32'h0;
      tx_full       = 4'h0;
      rx_empty      = 4'h0;

      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
      check("rst_action", {28'd0, action}, 32'd0);
      check("rst_mindex_index", {25'd0, mindex, index}, 32'd0);
      check("rst_din", din, 32'd0);
      check("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
      check("rst_rdata", bus.rsp_rdata, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

      send(1'b1, 8'h05, 32'h0000_E081, 1'b1, 32'h0, 1'b0, 2);
      check("instr_action", {28'd0, action}, 32'd1);
      check("instr_index", {27'd0, index}, 32'd5);
      check("instr_din", din, 32'h0000_E081);
      check("busy_ready", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      check("after_issue_action", {28'd0, action}, 32'd0);
      check("din_holds", din, 32'h0000_E081);

      send(1'b0, 8'h3E, 32'h0, 1'b1, 32'h0100_0000, 1'b0, 3);
      check("version_action", {28'd0, action}, 32'd0);

      send(1'b0, 8'h3D, 32'h0, 1'b1, 32'h0000_0ABC, 1'b0, 3);
      check("intr_action", {28'd0, action}, 32'd11);

      for (int i = 0; i < 7; i++) begin
         send(1'b1, waddr[i], 32'hA500_0000 | i, 1'b1, 32'h0, 1'b0, 2);
         check("wr_action", {28'd0, action}, {28'd0, wact[i]});
         check("wr_mindex", {30'd0, mindex}, {30'd0, wm[i]});
         check("wr_index", {27'd0, index}, {27'd0, widx[i]});
         check("wr_din", din, 32'hA500_0000 | i);
      end

      send(1'b0, 8'h35, 32'h0, 1'b1, 32'hD000_0001, 1'b0, 3);
      check("pull_action", {28'd0, action}, 32'd3);
      check("pull_mindex", {30'd0, mindex}, 32'd1);
      repeat (3) @(negedge clk);
      check("pull_hold1", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      check("pull_hold2", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      check("pull_hold_done", {31'd0, bus.req_ready}, 32'd1);

      tx_full  = 4'h3;
      rx_empty = 4'hC;
      send(1'b0, 8'h3F, 32'h0, 1'b1, 32'h0000_00C3, 1'b0, 1);
      check("fstat_no_action", {28'd0, action}, 32'd0);
      tx_full  = 4'h0;
      rx_empty = 4'h0;

      for (int i = 0; i < 6; i++) begin
         send(ew[i], ea[i], 32'h1234, 1'b1, 32'h0, 1'b1, 1);
         check("err_no_action", {28'd0, action}, 32'd0);
      end

      tx_full = 4'b0010;
      send(1'b1, 8'h31, 32'h0000_5555, 1'b1, 32'h0, 1'b0, 12);
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) @(negedge clk);
         check("push_wait_action", {28'd0, action}, 32'd0);
         check("push_wait_ready", {31'd0, bus.req_ready}, 32'd0);
      end
      tx_full = 4'b0000;
      @(negedge clk);
      check("push_action", {28'd0, action}, 32'd4);
      check("push_mindex", {30'd0, mindex}, 32'd1);
      check("push_din", din, 32'h0000_5555);
      repeat (2) @(negedge clk);
      check("push_hold1", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      check("push_hold2", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      check("push_hold_done", {31'd0, bus.req_ready}, 32'd1);

      rx_empty = 4'b0001;
      send(1'b0, 8'h34, 32'h0, 1'b1, 32'h0, 1'b1, 256);
      bad = 0;
      for (int k = 1; k <= 255; k++) begin
         if (k > 1) @(negedge clk);
         if (action !== 4'd0 || bus.rsp_valid !== 1'b0) bad++;
      end
      check("timeout_quiet", 32'(bad), 32'd0);
      @(negedge clk);
      check("timeout_err", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd3);
      rx_empty = 4'b0000;
      repeat (3) @(negedge clk);
      check("timeout_hold_done", {31'd0, bus.req_ready}, 32'd1);

      tx_full = 4'b0001;
      send(1'b1, 8'h30, 32'h77, 1'b0, 32'h0, 1'b0, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_action", {28'd0, action}, 32'd0);
      check("midrst_ready", {31'd0, bus.req_ready}, 32'd0);
      check("midrst_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tx_full = 4'b0000;
      repeat (5) @(negedge clk);
      check("postrst_ready", {31'd0, bus.req_ready}, 32'd1);
      check("postrst_action", {28'd0, action}, 32'd0);

      send(1'b1, 8'h3C, 32'h1, 1'b1, 32'h0, 1'b0, 2);
      check("recover_action", {28'd0, action}, 32'd6);
      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
